// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: moves whole cache lines or single words between a cache and a
// word-wide SRAM with a fixed read latency.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   mem_w_line / mem_r_line       line write / line read request (level)
//   mem_w_one  / mem_r_one        single-word write / read request (level)
//   mem_addr                      word address from the cache
//   line_store                    write data (word ops use entry 0)
//   line_read                     read data (word reads fill entry 0 only)
//   mem_ready                     high only while idle
//   mem_done                      one-cycle completion pulse
//   sram_en/sram_we/sram_addr/sram_wdata/sram_rdata   SRAM port
//   proto_err                     sticky protocol-violation flag

`ifndef CACHE_SIZE
`define CACHE_SIZE 8
`endif
`ifndef CACHE_BITS
`define CACHE_BITS 3
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

module mem_line_ctrl #(
    parameter int LINE_WORDS = `CACHE_SIZE,
    parameter int LINE_BITS  = `CACHE_BITS,
    parameter int ADDR_W     = `ADDR_SIZE,
    parameter int RD_LAT     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_w_line,
    input  logic                        mem_r_line,
    input  logic                        mem_w_one,
    input  logic                        mem_r_one,
    input  logic [ADDR_W-1:0]           mem_addr,
    input  logic [LINE_WORDS-1:0][31:0] line_store,
    output logic [LINE_WORDS-1:0][31:0] line_read,
    output logic                        mem_ready,
    output logic                        mem_done,
    output logic                        sram_en,
    output logic                        sram_we,
    output logic [ADDR_W-1:0]           sram_addr,
    output logic [31:0]                 sram_wdata,
    input  logic [31:0]                 sram_rdata,
    output logic                        proto_err
);

    localparam int CW = LINE_BITS + 1;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DONE, S_RELEASE} state_t;
    typedef enum logic [1:0] {OP_W_LINE, OP_R_LINE, OP_W_ONE, OP_R_ONE} op_t;

    state_t                      state, state_d;
    op_t                         op_q, op_sel;
    logic [ADDR_W-1:0]           addr_q;
    logic [LINE_WORDS-1:0][31:0] store_q;
    logic [CW-1:0]               issue_cnt, ret_cnt, n_words;
    logic [RD_LAT-1:0]           rd_pipe;
    logic [3:0]                  req, req_q, op_mask;
    logic [LINE_BITS-1:0]        idx;
    logic [ADDR_W-1:0]           word_addr;
    logic                        accept, is_line, sel_line, issue, capture, write_step;
    logic                        multi_req, stray_rise;

    // bit 0 has the highest priority
    assign req        = {mem_r_one, mem_w_one, mem_r_line, mem_w_line};
    assign is_line    = (op_q == OP_W_LINE) || (op_q == OP_R_LINE);
    assign sel_line   = (op_sel == OP_W_LINE) || (op_sel == OP_R_LINE);
    assign n_words    = is_line ? CW'(LINE_WORDS) : CW'(1);
    assign idx        = issue_cnt[LINE_BITS-1:0];
    // low address bits are replaced by the word index, so a line wraps within itself
    assign word_addr  = is_line ? {addr_q[ADDR_W-1:LINE_BITS], idx} : addr_q;
    // read pipe tap: a read issued RD_LAT cycles ago has its data on sram_rdata now
    assign capture    = (state == S_READ) && rd_pipe[RD_LAT-1];
    assign multi_req  = (req & (req - 4'd1)) != 4'd0;
    assign op_mask    = 4'b0001 << op_q;
    assign stray_rise = |((req & ~req_q) & ~op_mask);

    always_comb begin
        op_sel = OP_R_ONE;
        if (mem_w_line)      op_sel = OP_W_LINE;
        else if (mem_r_line) op_sel = OP_R_LINE;
        else if (mem_w_one)  op_sel = OP_W_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        issue      = 1'b0;
        write_step = 1'b0;
        mem_ready  = 1'b0;
        mem_done   = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (state)
            S_IDLE: begin
                mem_ready = 1'b1;
                if (|req) begin
                    accept  = 1'b1;
                    state_d = (op_sel == OP_W_LINE || op_sel == OP_W_ONE) ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                write_step = 1'b1;
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = word_addr;
                sram_wdata = store_q[idx];
                if (issue_cnt == n_words - CW'(1)) state_d = S_DONE;
            end
            S_READ: begin
                if (issue_cnt < n_words) begin
                    issue     = 1'b1;
                    sram_en   = 1'b1;
                    sram_addr = word_addr;
                end
                if (capture && ret_cnt == n_words - CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                mem_done = 1'b1;
                state_d  = S_RELEASE;
            end
            S_RELEASE: begin
                if (!(|req)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_W_LINE;
            addr_q    <= '0;
            store_q   <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            rd_pipe   <= '0;
            req_q     <= '0;
            line_read <= '0;
            proto_err <= 1'b0;
        end else begin
            req_q      <= req;
            rd_pipe[0] <= issue;
            for (int unsigned i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];

            if (accept) begin
                op_q      <= op_sel;
                addr_q    <= sel_line ? {mem_addr[ADDR_W-1:LINE_BITS], {LINE_BITS{1'b0}}} : mem_addr;
                store_q   <= line_store;
                issue_cnt <= '0;
                ret_cnt   <= '0;
                if (multi_req) proto_err <= 1'b1;
            end

            if (write_step || issue) issue_cnt <= issue_cnt + CW'(1);

            if (capture) begin
                line_read[is_line ? ret_cnt[LINE_BITS-1:0] : '0] <= sram_rdata;
                ret_cnt <= ret_cnt + CW'(1);
            end

            if ((state == S_WRITE || state == S_READ || state == S_DONE) && stray_rise)
                proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Testbench for mem_line_ctrl: SRAM model with fixed read latency, reference
// memory/line model, directed scenarios followed by randomized operations.
module tb_mem_line_ctrl;

    localparam int LW = 8;
    localparam int LB = 3;
    localparam int AW = 8;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_w_line = 1'b0, mem_r_line = 1'b0, mem_w_one = 1'b0, mem_r_one = 1'b0;
    logic [AW-1:0]        mem_addr = '0;
    logic [LW-1:0][31:0]  line_store = '0;
    logic [LW-1:0][31:0]  line_read;
    logic                 mem_ready, mem_done, sram_en, sram_we, proto_err;
    logic [AW-1:0]        sram_addr;
    logic [31:0]          sram_wdata, sram_rdata;

    mem_line_ctrl #(.LINE_WORDS(LW), .LINE_BITS(LB), .ADDR_W(AW), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .mem_w_line(mem_w_line), .mem_r_line(mem_r_line),
        .mem_w_one(mem_w_one), .mem_r_one(mem_r_one),
        .mem_addr(mem_addr), .line_store(line_store), .line_read(line_read),
        .mem_ready(mem_ready), .mem_done(mem_done),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: writes on the edge, read data visible RL cycles after the strobe
    logic [31:0]   sram [256] = '{default: 32'h0};
    logic          rv [RL] = '{default: 1'b0};
    logic [AW-1:0] ra [RL] = '{default: '0};
    always @(posedge clk) begin
        if (sram_en && sram_we) sram[sram_addr] <= sram_wdata;
        rv[0] <= sram_en && !sram_we;
        ra[0] <= sram_addr;
        for (int i = 1; i < RL; i++) begin
            rv[i] <= rv[i-1];
            ra[i] <= ra[i-1];
        end
    end
    assign sram_rdata = rv[RL-1] ? sram[ra[RL-1]] : 32'h5A5A_0BAD;

    // strobe / done monitor
    typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [31:0] wdata; } ev_t;
    ev_t evq[$];
    int  doneq[$];
    always @(negedge clk) begin
        if (sram_en) evq.push_back('{cyc, sram_we, sram_addr, sram_wdata});
        if (mem_done) doneq.push_back(cyc);
    end

    // reference model
    logic [31:0]         ref_mem [256];
    logic [LW-1:0][31:0] exp_line = '0;
    logic                exp_proto = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic set_reqs(input logic [3:0] r);
        mem_w_line = r[0];
        mem_r_line = r[1];
        mem_w_one  = r[2];
        mem_r_one  = r[3];
    endtask

    task automatic run_op(input logic [3:0] reqs, input logic [AW-1:0] addr,
                          input logic [LW-1:0][31:0] data, input int hold);
        int t, d, rdy, k, op, n, exp_done, exp_rdy, got_done;
        logic [AW-1:0] base, a;
        bit line, wr;
        k = 0;
        @(negedge clk);
        while (!mem_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (mem_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_wait: mem_ready=%b required 1", mem_ready);
        end
        op   = reqs[0] ? 0 : reqs[1] ? 1 : reqs[2] ? 2 : 3;
        line = (op < 2);
        wr   = (op == 0 || op == 2);
        n    = line ? LW : 1;
        base = line ? (addr & ~AW'(LW - 1)) : addr;

        mem_addr   = addr;
        line_store = data;
        set_reqs(reqs);
        t = cyc;
        evq.delete();
        doneq.delete();
        d = -1;
        rdy = -1;
        for (int j = 1; j <= 200 && !(rdy >= 0 && d >= 0); j++) begin
            @(negedge clk);
            if (j == 1) begin
                mem_addr = AW'($urandom);
                for (int i = 0; i < LW; i++) line_store[i] = $urandom;
            end
            if (mem_ready && rdy < 0) rdy = cyc;
            if (j == hold) begin
                set_reqs(4'b0000);
                d = cyc;
            end
        end
        set_reqs(4'b0000);
        if (d < 0) d = cyc;

        exp_done = wr ? t + n + 1 : t + n + RL + 1;
        exp_rdy  = (exp_done + 2 > d + 1) ? exp_done + 2 : d + 1;

        got_done = (doneq.size() > 0) ? doneq[0] : -1;
        n_cmp++;
        if (doneq.size() != 1 || got_done != exp_done) begin
            n_bad++;
            $display("FAIL done_cycle op=%0d t=%0d: got %0d pulses first at %0d, required 1 pulse at %0d",
                     op, t, doneq.size(), got_done, exp_done);
        end

        n_cmp++;
        if (evq.size() != n) begin
            n_bad++;
            $display("FAIL strobe_count op=%0d t=%0d: got %0d, required %0d", op, t, evq.size(), n);
        end
        for (int i = 0; i < n && i < evq.size(); i++) begin
            a = line ? base + AW'(i) : addr;
            n_cmp++;
            if (evq[i].cyc != t + 1 + i || evq[i].we !== wr || evq[i].addr !== a ||
                (wr && evq[i].wdata !== data[i])) begin
                n_bad++;
                $display("FAIL strobe op=%0d i=%0d: got cyc=%0d we=%b addr=%h wdata=%h, required cyc=%0d we=%b addr=%h wdata=%h",
                         op, i, evq[i].cyc, evq[i].we, evq[i].addr, evq[i].wdata,
                         t + 1 + i, wr, a, wr ? data[i] : evq[i].wdata);
            end
        end

        n_cmp++;
        if (rdy != exp_rdy) begin
            n_bad++;
            $display("FAIL ready_return op=%0d t=%0d: got cycle %0d, required %0d", op, t, rdy, exp_rdy);
        end

        for (int i = 0; i < n; i++) begin
            a = line ? base + AW'(i) : addr;
            if (wr) ref_mem[a] = data[i];
            else    exp_line[line ? i : 0] = ref_mem[a];
        end
        exp_proto = exp_proto | ($countones(reqs) > 1);

        n_cmp++;
        if (line_read !== exp_line) begin
            n_bad++;
            $display("FAIL line_read op=%0d t=%0d: got %h, required %h", op, t, line_read, exp_line);
        end
        n_cmp++;
        if (proto_err !== exp_proto) begin
            n_bad++;
            $display("FAIL proto_err op=%0d t=%0d: got %b, required %b", op, t, proto_err, exp_proto);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_cmp++;
        if (mem_ready !== 1'b1 || mem_done !== 1'b0 || sram_en !== 1'b0 || sram_we !== 1'b0 ||
            sram_addr !== '0 || sram_wdata !== '0) begin
            n_bad++;
            $display("FAIL %s_ctrl: ready=%b done=%b en=%b we=%b addr=%h wdata=%h, required 1 0 0 0 0 0",
                     tag, mem_ready, mem_done, sram_en, sram_we, sram_addr, sram_wdata);
        end
        n_cmp++;
        if (line_read !== '0) begin
            n_bad++;
            $display("FAIL %s_line_read: got %h, required 0", tag, line_read);
        end
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_proto: got %b, required 0", tag, proto_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic test_line_write();
        logic [LW-1:0][31:0] d;
        for (int i = 0; i < LW; i++) d[i] = 32'hA0 + 32'(i);
        run_op(4'b0001, 8'h13, d, LW + 1);
    endtask

    task automatic test_line_read();
        logic [LW-1:0][31:0] d;
        for (int i = 0; i < LW; i++) d[i] = $urandom;
        run_op(4'b0010, 8'h13, d, LW + RL + 1);
    endtask

    task automatic test_word_ops();
        logic [LW-1:0][31:0] d;
        for (int i = 0; i < LW; i++) d[i] = $urandom;
        d[0] = 32'hDEADBEEF;
        run_op(4'b0100, 8'h2C, d, 2);
        for (int i = 0; i < LW; i++) d[i] = $urandom;
        run_op(4'b1000, 8'h2C, d, RL + 2);
    endtask

    task automatic test_release_hold();
        logic [LW-1:0][31:0] d;
        for (int i = 0; i < LW; i++) d[i] = $urandom;
        // word write: done at T+2, held through T+5, dropped at T+6
        run_op(4'b0100, AW'($urandom), d, 6);
    endtask

    task automatic test_random(input int count);
        logic [LW-1:0][31:0] d;
        logic [3:0] r;
        for (int k = 0; k < count; k++) begin
            for (int i = 0; i < LW; i++) d[i] = $urandom;
            r = 4'b0001 << $urandom_range(0, 3);
            run_op(r, AW'($urandom), d, int'($urandom_range(1, 16)));
        end
    endtask

    task automatic test_multi_req();
        logic [LW-1:0][31:0] d;
        for (int i = 0; i < LW; i++) d[i] = $urandom;
        run_op(4'b1001, AW'($urandom), d, 4);
        test_random(3);
    endtask

    task automatic test_rst_mid_read();
        logic [3:0] r;
        int t;
        @(negedge clk);
        while (!mem_ready) @(negedge clk);
        mem_addr = AW'($urandom);
        set_reqs(4'b0010);
        t = cyc;
        while (cyc < t + 4) @(negedge clk);
        rst = 1'b1;
        set_reqs(4'b0000);
        #1;
        check_idle_outputs("rst_mid");
        evq.delete();
        doneq.delete();
        exp_line = '0;
        exp_proto = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (evq.size() != 0 || doneq.size() != 0) begin
            n_bad++;
            $display("FAIL rst_quiet: got %0d strobes %0d done pulses, required 0 0", evq.size(), doneq.size());
        end
        check_idle_outputs("rst_after");
        r = 4'b0010;
        test_random(2);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        test_reset();
        test_line_write();
        test_line_read();
        test_word_ops();
        test_release_hold();
        test_random(40);
        test_multi_req();
        test_rst_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
